// File: rtl/determ_decode_fxp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// determ_decode_fxp_ctrl_pkg
// Shared definitions for the deterministic-bitstream decode controller and
// its accumulate datapath:
//   - state_e      : controller state encoding (IDLE / RUN / HOLD)
//   - fxp_one()    : the +1.0 constant in a signed Q(iw).(bw-iw) format
//   - sat_max()    : most positive raw value of a signed bw-bit word
//   - sat_min()    : most negative raw value of a signed bw-bit word
// All helpers return 64-bit signed values; callers slice to their width.
// ----------------------------------------------------------------------------
package determ_decode_fxp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int FXP_CALC_W = 64;

    // +1.0 in Q(iw).(bw-iw): a one at the first integer bit position.
    function automatic logic signed [FXP_CALC_W-1:0] fxp_one(input int bw, input int iw);
        return 64'sd1 <<< (bw - iw);
    endfunction

    // Upper saturation bound of a signed bw-bit word.
    function automatic logic signed [FXP_CALC_W-1:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    // Lower saturation bound of a signed bw-bit word.
    function automatic logic signed [FXP_CALC_W-1:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

endpackage

// File: rtl/determ_add_fxp.sv
// ----------------------------------------------------------------------------
// determ_add_fxp
// Shared deterministic add-with-FXP datapath: adds the value of one
// deterministic bitstream bit (1 -> +1.0, 0 -> -1.0) to a signed fixed-point
// operand in format Q(INT_WIDTH).(BIT_WIDTH-INT_WIDTH). Purely combinational;
// the operand is expected to have headroom, the sum wraps otherwise.
// Ports:
//   i_a  : deterministic bit
//   i_b  : signed FXP operand
//   o_y  : i_b + (+1.0 or -1.0)
// ----------------------------------------------------------------------------
module determ_add_fxp
    import determ_decode_fxp_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int INT_WIDTH = 1
) (
    input  logic                        i_a,
    input  logic signed [BIT_WIDTH-1:0] i_b,
    output logic signed [BIT_WIDTH-1:0] o_y
);

    localparam logic signed [FXP_CALC_W-1:0] ONE_WIDE = fxp_one(BIT_WIDTH, INT_WIDTH);
    localparam logic signed [BIT_WIDTH-1:0]  ONE      = ONE_WIDE[BIT_WIDTH-1:0];

    // Step the operand by +/-1.0 depending on the bit.
    always_comb begin
        o_y = i_b;
        if (i_a) begin
            o_y = i_b + ONE;
        end else begin
            o_y = i_b - ONE;
        end
    end

endmodule

// File: rtl/determ_decode_fxp_ctrl.sv
// ----------------------------------------------------------------------------
// determ_decode_fxp_ctrl
// Decodes a window of 2^LOG2_LEN deterministic bitstream bits (1 = +1.0,
// 0 = -1.0) into their signed fixed-point average, saturated to BIT_WIDTH
// bits in format Q(INT_WIDTH).(BIT_WIDTH-INT_WIDTH).
// Ports:
//   CLK, nRST  : rising-edge clock, asynchronous active-low reset
//   start      : begins a window (sampled only in IDLE)
//   in_bit/in_valid/in_ready    : input bit handshake (accepted in RUN)
//   out_value/out_valid/out_ready : result handshake (presented in HOLD)
//   busy       : high in RUN or HOLD
//   abort      : only with DETERM_DECODE_ABORT_EN defined; drops the current
//                window and returns to IDLE
// Optional feature macro: DETERM_DECODE_ABORT_EN
// ----------------------------------------------------------------------------
module determ_decode_fxp_ctrl
    import determ_decode_fxp_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int INT_WIDTH = 1,
    parameter int LOG2_LEN  = 3
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 start,
    input  logic                 in_bit,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] out_value,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef DETERM_DECODE_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy
);

    // The accumulator carries one integer bit beyond BIT_WIDTH+LOG2_LEN so
    // that the all-ones sum of +2^LOG2_LEN is representable and saturates
    // correctly instead of wrapping to the most negative value.
    localparam int ACC_W   = BIT_WIDTH + LOG2_LEN + 1;
    localparam int ACC_INT = INT_WIDTH + LOG2_LEN + 1;
    localparam int CNT_W   = LOG2_LEN + 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2_LEN) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic signed [FXP_CALC_W-1:0] SAT_HI = sat_max(BIT_WIDTH);
    localparam logic signed [FXP_CALC_W-1:0] SAT_LO = sat_min(BIT_WIDTH);

    state_e                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_count;
    logic [BIT_WIDTH-1:0]     r_out_value;
    logic                     r_out_valid;
    logic                     r_in_ready;
    logic                     r_busy;

    logic signed [ACC_W-1:0]      w_acc_next;
    logic                         w_abort;
    logic                         w_in_ready;
    logic                         w_accept;
    logic                         w_last;
    logic signed [FXP_CALC_W-1:0] w_sum_wide;
    logic signed [FXP_CALC_W-1:0] w_avg_wide;
    logic [BIT_WIDTH-1:0]         w_sat_value;

`ifdef DETERM_DECODE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // A bit offered during an abort cycle must not be taken.
    assign w_in_ready = r_in_ready & ~w_abort;
    assign w_accept   = in_valid & w_in_ready;
    assign w_last     = (r_count == LAST_IDX);

    determ_add_fxp #(
        .BIT_WIDTH (ACC_W),
        .INT_WIDTH (ACC_INT)
    ) u_add (
        .i_a (in_bit),
        .i_b (r_acc),
        .o_y (w_acc_next)
    );

    // Average of the final sum: every step is an integer multiple of 1.0,
    // so the arithmetic shift is exact.
    assign w_sum_wide = {{(FXP_CALC_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
    assign w_avg_wide = w_sum_wide >>> LOG2_LEN;

    // Clamp the average to the signed BIT_WIDTH output range.
    always_comb begin
        w_sat_value = w_avg_wide[BIT_WIDTH-1:0];
        if (w_avg_wide > SAT_HI) begin
            w_sat_value = SAT_HI[BIT_WIDTH-1:0];
        end else if (w_avg_wide < SAT_LO) begin
            w_sat_value = SAT_LO[BIT_WIDTH-1:0];
        end else begin
            w_sat_value = w_avg_wide[BIT_WIDTH-1:0];
        end
    end

    // Controller FSM with all handshake outputs registered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_out_value <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !w_abort) begin
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_accept) begin
                        r_acc <= w_acc_next;
                        if (w_last) begin
                            r_count     <= '0;
                            r_out_value <= w_sat_value;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_HOLD;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_abort) begin
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_value = r_out_value;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_determ_decode_fxp_ctrl.sv
module tb_determ_decode_fxp_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_value;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        abort;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    determ_decode_fxp_ctrl #(
        .BIT_WIDTH (16),
        .INT_WIDTH (1),
        .LOG2_LEN  (3)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (start),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DETERM_DECODE_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [7:0]  bits;      // bit i is presented i-th
        int          stall_at;  // bit index before which in_valid drops (-1 none)
        int          stall_len;
        int          hold_len;  // cycles out_ready stays low in HOLD
        bit          poke;      // pulse start during RUN/HOLD
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: average of +/-1.0 values in Q1.15, clamped to 16-bit signed.
    function automatic logic [15:0] model(input logic [7:0] bits);
        int ones;
        int v;
        ones = $countones(bits);
        v = ((2 * ones - 8) * 32768) / 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_window(input vec_t v, input string name);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({name, "_busy_run"}, 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == v.stall_at) begin
                in_valid = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    start = v.poke;
                    step();
                    chk({name, "_stall_ready"}, 32'(in_ready), 32'd1);
                    chk({name, "_stall_ovalid"}, 32'(out_valid), 32'd0);
                end
                start = 1'b0;
            end
            in_bit   = v.bits[i];
            in_valid = 1'b1;
            wait_ready();
            step();
            in_valid = 1'b0;
            if (i < 7) chk({name, "_no_early_valid"}, 32'(out_valid), 32'd0);
        end
        chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_out_value"}, 32'(out_value), 32'(v.exp));
        chk({name, "_in_ready_hold"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < v.hold_len; h++) begin
            start = v.poke;
            step();
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_value"}, 32'(out_value), 32'(v.exp));
        end
        start     = v.poke;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk({name, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        step();
        chk({name, "_still_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[5];
    vec_t rv;

    initial begin
        nRST = 1'b0; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; abort = 1'b0;

        vecs[0] = '{8'hFF, -1, 0, 0, 1'b0, 16'h7FFF};
        vecs[1] = '{8'h00, -1, 0, 0, 1'b0, 16'h8000};
        vecs[2] = '{8'h3F, -1, 0, 0, 1'b0, 16'h4000};
        vecs[3] = '{8'h55, -1, 0, 0, 1'b0, 16'h0000};
        vecs[4] = '{8'h3F,  3, 5, 4, 1'b1, 16'h4000};

        repeat (2) step();
        chk("rst_out_value", 32'(out_value), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        nRST = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        for (int k = 0; k < 5; k++) begin
            run_window(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset in the middle of a window, then a clean window.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_bit = 1'b1; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
        end
        #2 nRST = 1'b0;
        #1;
        chk("midrst_out_value", 32'(out_value), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        step();
        nRST = 1'b1;
        step();
        run_window('{8'h03, -1, 0, 0, 1'b0, 16'hC000}, "after_rst");

`ifdef DETERM_DECODE_ABORT_EN
        // Abort mid-RUN: offered bit refused, window dropped.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_bit = 1'b1; in_valid = 1'b1; step(); in_valid = 1'b0;
        end
        abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1; start = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        step();
        abort = 1'b0; in_valid = 1'b0; start = 1'b0;
        chk("abort_run_busy", 32'(busy), 32'd0);
        run_window('{8'h00, -1, 0, 0, 1'b0, 16'h8000}, "after_abort_run");
        // Abort in HOLD with out_ready also high.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_bit = 1'b1; in_valid = 1'b1; step(); in_valid = 1'b0;
        end
        chk("abort_hold_valid", 32'(out_valid), 32'd1);
        abort = 1'b1; out_ready = 1'b1;
        step();
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_hold_drop", 32'(out_valid), 32'd0);
        chk("abort_hold_busy", 32'(busy), 32'd0);
        run_window('{8'h00, -1, 0, 0, 1'b0, 16'h8000}, "after_abort_hold");
`endif

        // Randomized windows against the reference model.
        for (int r = 0; r < 20; r++) begin
            rv.bits      = 8'($urandom);
            rv.stall_at  = int'($urandom_range(0, 8)) - 1;
            rv.stall_len = int'($urandom_range(0, 3));
            rv.hold_len  = int'($urandom_range(0, 3));
            rv.poke      = 1'($urandom);
            rv.exp       = model(rv.bits);
            run_window(rv, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
